stream_eq_checker: RTL and testbench
====================================

STREAM_EQ_CHECKER -- requirements
Module: stream_eq_checker

Interface
REQ-001 Parameter DEPTH, 4, per-side reorder FIFO depth in beats; power of two, at least 2.
REQ-002 Parameter EXPECT_CNT, 16, number of beat pairs compared before a verdict; range 1..65535.
REQ-003 ap_clk  in  1  single clock; every register is rising-edge.
REQ-004 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle pulse that arms a check run.
REQ-006 arg_0_TREADY  in  1  shared sink ready driven to both designs under comparison.
REQ-007 ila_arg_0_TDATA / ila_arg_0_TVALID  in  8 / 1  ILA output stream.
REQ-008 hls_arg_0_TDATA / hls_arg_0_TVALID  in  8 / 1  HLS output stream.
REQ-009 busy / pass / fail  out  1 each  verdict state flags.
REQ-010 cmp_cnt / mismatch_cnt  out  16 each  number of pairs compared / number of pairs that differed.
REQ-011 first_bad_idx  out  16  pair index of the first mismatch.
REQ-012 first_bad_ila / first_bad_hls  out  8 each  data values at the first mismatch.
REQ-013 overflow  out  1  sticky flag set when a FIFO drops a beat.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PASS and FAIL; busy=RUN, pass=PASS, fail=FAIL, all registered.
REQ-015 A start pulse in IDLE, PASS or FAIL SHALL enter RUN, clear both FIFOs, all counters, first_bad_* and overflow; start is ignored while in RUN.
REQ-016 In RUN, a side's beat SHALL be accepted when its TVALID=1 and arg_0_TREADY=1, and pushed to that side's FIFO; beats arriving outside RUN SHALL be ignored.
REQ-017 In RUN, when both FIFOs are non-empty, one entry SHALL be popped from each FIFO in the same cycle and the two entries compared; the compare result takes effect at that cycle's edge.
REQ-018 Minimum latency from the later of two paired beats being accepted to cmp_cnt incrementing SHALL be 1 cycle (push edge, then pop edge).
REQ-019 Push and pop on the same FIFO in the same cycle SHALL be allowed, including when the FIFO is full.
REQ-020 A push to a full FIFO with no pop in the same cycle SHALL drop the beat, set overflow, and move the FSM to FAIL at the same edge.
REQ-021 Each pop SHALL increment cmp_cnt by 1.
REQ-022 On a mismatching pop, mismatch_cnt SHALL increment, saturating at 16'hFFFF.
REQ-023 On the first mismatching pop only, the block SHALL capture first_bad_idx (cmp_cnt before the increment), first_bad_ila and first_bad_hls.
REQ-024 When cmp_cnt reaches EXPECT_CNT, the FSM SHALL go to PASS if mismatch_cnt==0 (including the final pair), otherwise to FAIL.
REQ-025 Beats and FIFO contents left over after the verdict SHALL be ignored.
REQ-026 If overflow and the EXPECT_CNT terminal compare occur in the same cycle, the FSM SHALL go to FAIL.
REQ-027 FIFO read and write pointers SHALL wrap modulo DEPTH, with a separate occupancy count so that full and empty are distinguished.

Reset
REQ-028 While ap_rst_n=0, state SHALL be IDLE, both FIFOs SHALL be empty, and every output SHALL be 0, independent of ap_clk.
REQ-029 Reset asserted mid-RUN SHALL abandon the run with no verdict; the block then requires a new start.

Configuration
REQ-030 With STREAM_EQ_CHECKER_STOP_ON_FAIL_EN defined, the first mismatching pop SHALL move the FSM to FAIL at that edge and stop all further pops and counting.
REQ-031 Without STREAM_EQ_CHECKER_STOP_ON_FAIL_EN, the block SHALL keep comparing until cmp_cnt reaches EXPECT_CNT and then apply the verdict rule of REQ-024.

Verification
REQ-032 EXPECT_CNT=16, 16 identical beats on both sides with ILA 3 cycles ahead of HLS -> pass=1, cmp_cnt=16, mismatch_cnt=0.
REQ-033 Pair 5: ILA=8'h3C, HLS=8'h3D, all other pairs equal -> fail=1, first_bad_idx=5, first_bad_ila=8'h3C, first_bad_hls=8'h3D; mismatch_cnt=1 (macro off) or cmp_cnt=6 (macro on).
REQ-034 DEPTH=4, 5 ILA beats with no HLS beats -> fifth beat dropped, overflow=1, fail=1.
REQ-035 arg_0_TREADY held at 0 while both TVALID=1 for 10 cycles -> no push, cmp_cnt stays 0, busy stays 1.
REQ-036 ap_rst_n pulsed low after 7 compares mid-RUN -> all outputs 0 immediately; a new start followed by 16 equal pairs -> pass=1.

Source files
------------

// File: rtl/stream_eq_checker_if.sv
// Paired AXI-stream-style inputs under comparison: ILA and HLS data/valid plus the shared sink ready.
// The bench (master) drives everything; the checker (slave) only observes.
interface stream_eq_checker_if;
  logic [7:0] ila_arg_0_TDATA;
  logic       ila_arg_0_TVALID;
  logic [7:0] hls_arg_0_TDATA;
  logic       hls_arg_0_TVALID;
  logic       arg_0_TREADY;

  modport master (
    output ila_arg_0_TDATA, ila_arg_0_TVALID,
    output hls_arg_0_TDATA, hls_arg_0_TVALID,
    output arg_0_TREADY
  );

  modport slave (
    input ila_arg_0_TDATA, ila_arg_0_TVALID,
    input hls_arg_0_TDATA, hls_arg_0_TVALID,
    input arg_0_TREADY
  );
endinterface

// File: rtl/stream_eq_checker.sv
// Compares ILA and HLS streams beat-by-beat through per-side reorder FIFOs; compare lands 1 cycle after the later beat.
// Never backpressures (observes shared ready); full FIFO drops beat -> overflow+FAIL. STREAM_EQ_CHECKER_STOP_ON_FAIL_EN: stop on first mismatch.
module stream_eq_checker #(
  parameter int DEPTH      = 4,
  parameter int EXPECT_CNT = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               start,
  stream_eq_checker_if.slave s_if,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic [15:0]        cmp_cnt,
  output logic [15:0]        mismatch_cnt,
  output logic [15:0]        first_bad_idx,
  output logic [7:0]         first_bad_ila,
  output logic [7:0]         first_bad_hls,
  output logic               overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   TERM_CNT = 16'(EXPECT_CNT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t          state_q;
  logic            busy_q, pass_q, fail_q, overflow_q;
  logic [15:0]     cmp_cnt_q, mm_cnt_q, first_idx_q;
  logic [7:0]      first_ila_q, first_hls_q;
  logic [AW-1:0]   ila_wr_q, ila_rd_q, hls_wr_q, hls_rd_q;
  logic [CW-1:0]   ila_cnt_q, hls_cnt_q;
  logic [7:0]      ila_mem_q [DEPTH];
  logic [7:0]      hls_mem_q [DEPTH];

  logic            run, pop, mism, drop, abort;
  logic            ila_acc, hls_acc, ila_push, hls_push;
  logic [7:0]      ila_head, hls_head;
  logic [AW-1:0]   ila_wr_d, ila_rd_d, hls_wr_d, hls_rd_d;
  logic [CW-1:0]   ila_cnt_d, hls_cnt_d;
  logic [15:0]     cmp_cnt_d, mm_cnt_d;

  always_comb begin
    run       = (state_q == S_RUN);
    pop       = run && (ila_cnt_q != '0) && (hls_cnt_q != '0);
    ila_head  = ila_mem_q[ila_rd_q];
    hls_head  = hls_mem_q[hls_rd_q];
    mism      = pop && (ila_head != hls_head);
    ila_acc   = run && s_if.ila_arg_0_TVALID && s_if.arg_0_TREADY;
    hls_acc   = run && s_if.hls_arg_0_TVALID && s_if.arg_0_TREADY;
    // A simultaneous pop frees the slot, so a full FIFO can still take the beat.
    ila_push  = ila_acc && ((ila_cnt_q != FULL_CNT) || pop);
    hls_push  = hls_acc && ((hls_cnt_q != FULL_CNT) || pop);
    drop      = (ila_acc && !ila_push) || (hls_acc && !hls_push);
    ila_wr_d  = ila_wr_q + AW'(ila_push);
    hls_wr_d  = hls_wr_q + AW'(hls_push);
    ila_rd_d  = ila_rd_q + AW'(pop);
    hls_rd_d  = hls_rd_q + AW'(pop);
    ila_cnt_d = ila_cnt_q + CW'(ila_push) - CW'(pop);
    hls_cnt_d = hls_cnt_q + CW'(hls_push) - CW'(pop);
    cmp_cnt_d = cmp_cnt_q + 16'(pop);
    mm_cnt_d  = (mism && (mm_cnt_q != 16'hFFFF)) ? mm_cnt_q + 16'd1 : mm_cnt_q;
  end

`ifdef STREAM_EQ_CHECKER_STOP_ON_FAIL_EN
  assign abort = drop || mism;
`else
  assign abort = drop;
`endif

  always_ff @(posedge ap_clk) begin
    if (ila_push) ila_mem_q[ila_wr_q] <= s_if.ila_arg_0_TDATA;
    if (hls_push) hls_mem_q[hls_wr_q] <= s_if.hls_arg_0_TDATA;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      overflow_q  <= 1'b0;
      cmp_cnt_q   <= '0;
      mm_cnt_q    <= '0;
      first_idx_q <= '0;
      first_ila_q <= '0;
      first_hls_q <= '0;
      ila_wr_q    <= '0;
      ila_rd_q    <= '0;
      ila_cnt_q   <= '0;
      hls_wr_q    <= '0;
      hls_rd_q    <= '0;
      hls_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          ila_wr_q  <= ila_wr_d;
          ila_rd_q  <= ila_rd_d;
          ila_cnt_q <= ila_cnt_d;
          hls_wr_q  <= hls_wr_d;
          hls_rd_q  <= hls_rd_d;
          hls_cnt_q <= hls_cnt_d;
          cmp_cnt_q <= cmp_cnt_d;
          mm_cnt_q  <= mm_cnt_d;
          if (mism && (mm_cnt_q == '0)) begin
            first_idx_q <= cmp_cnt_q;
            first_ila_q <= ila_head;
            first_hls_q <= hls_head;
          end
          if (drop) overflow_q <= 1'b1;
          if (abort) begin
            state_q <= S_FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end else if (cmp_cnt_d == TERM_CNT) begin
            busy_q <= 1'b0;
            if (mm_cnt_d == '0) begin
              state_q <= S_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            overflow_q  <= 1'b0;
            cmp_cnt_q   <= '0;
            mm_cnt_q    <= '0;
            first_idx_q <= '0;
            first_ila_q <= '0;
            first_hls_q <= '0;
            ila_wr_q    <= '0;
            ila_rd_q    <= '0;
            ila_cnt_q   <= '0;
            hls_wr_q    <= '0;
            hls_rd_q    <= '0;
            hls_cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign overflow      = overflow_q;
  assign cmp_cnt       = cmp_cnt_q;
  assign mismatch_cnt  = mm_cnt_q;
  assign first_bad_idx = first_idx_q;
  assign first_bad_ila = first_ila_q;
  assign first_bad_hls = first_hls_q;
endmodule

// File: tb/tb_stream_eq_checker.sv
// Scoreboarded bench for stream_eq_checker: queue-based pairing model feeds expected compares to a negedge monitor.
`timescale 1ns/1ps
module tb_stream_eq_checker;
  localparam int DEPTH      = 4;
  localparam int EXPECT_CNT = 16;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, pass, fail, overflow;
  logic [15:0] cmp_cnt, mismatch_cnt, first_bad_idx;
  logic [7:0]  first_bad_ila, first_bad_hls;

  stream_eq_checker_if sif();

  stream_eq_checker #(.DEPTH(DEPTH), .EXPECT_CNT(EXPECT_CNT)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .s_if(sif),
    .busy(busy), .pass(pass), .fail(fail),
    .cmp_cnt(cmp_cnt), .mismatch_cnt(mismatch_cnt), .first_bad_idx(first_bad_idx),
    .first_bad_ila(first_bad_ila), .first_bad_hls(first_bad_hls), .overflow(overflow)
  );

  always #5 ap_clk = ~ap_clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: unpaired beats per side and the running verdict.
  logic [7:0] m_ila_q[$];
  logic [7:0] m_hls_q[$];
  int         exp_cnt_q[$];
  int         exp_mm_q[$];
  bit         m_run;
  int         m_pairs, m_mm, m_first_idx;
  logic [7:0] m_first_ila, m_first_hls;
  logic [7:0] ila_d[64];
  logic [7:0] hls_d[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_beat(input bit is_ila, input logic [7:0] d);
    logic [7:0] a, b;
    if (!m_run) return;
    if (is_ila) m_ila_q.push_back(d); else m_hls_q.push_back(d);
    if (m_ila_q.size() > 0 && m_hls_q.size() > 0) begin
      a = m_ila_q.pop_front();
      b = m_hls_q.pop_front();
      if (a != b) begin
        if (m_mm == 0) begin
          m_first_idx = m_pairs;
          m_first_ila = a;
          m_first_hls = b;
        end
        if (m_mm != 16'hFFFF) m_mm++;
      end
      m_pairs++;
      exp_cnt_q.push_back(m_pairs);
      exp_mm_q.push_back(m_mm);
      if (m_pairs == EXPECT_CNT) m_run = 0;
`ifdef STREAM_EQ_CHECKER_STOP_ON_FAIL_EN
      if (a != b) m_run = 0;
`endif
    end
  endtask

  // Monitor: every increment of cmp_cnt must match the next expected compare.
  logic [15:0] prev_cnt = '0;
  always @(negedge ap_clk) begin
    int c, m;
    if (cmp_cnt !== prev_cnt) begin
      if (cmp_cnt > prev_cnt) begin
        if (exp_cnt_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_compare: cmp_cnt=%0d with no pending expectation", cmp_cnt);
        end else begin
          c = exp_cnt_q.pop_front();
          m = exp_mm_q.pop_front();
          check("mon_cmp_cnt", 32'(cmp_cnt), c);
          check("mon_mismatch_cnt", 32'(mismatch_cnt), m);
        end
      end
      prev_cnt = cmp_cnt;
    end
  end

  task automatic set_idle_inputs();
    sif.ila_arg_0_TVALID = 1'b0;
    sif.hls_arg_0_TVALID = 1'b0;
    sif.ila_arg_0_TDATA  = 8'h00;
    sif.hls_arg_0_TDATA  = 8'h00;
    sif.arg_0_TREADY     = 1'b1;
  endtask

  task automatic do_start();
    m_ila_q.delete();
    m_hls_q.delete();
    m_run = 1;
    m_pairs = 0;
    m_mm = 0;
    m_first_idx = 0;
    m_first_ila = 8'h00;
    m_first_hls = 8'h00;
    start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input int n, input int lead, input bit rnd);
    int ii = 0, hi = 0, cyc = 0, tail = 0;
    while (cyc < 600 && tail < 4) begin
      bit iv, hv, rd;
      if (rnd) begin
        rd = ($urandom_range(0, 3) != 0);
        iv = (ii < n) && ($urandom_range(0, 1) == 1) && (m_ila_q.size() < DEPTH - 1);
        hv = (hi < n) && ($urandom_range(0, 1) == 1) && (m_hls_q.size() < DEPTH - 1);
      end else begin
        rd = 1'b1;
        iv = (ii < n);
        hv = (hi < n) && (cyc >= lead);
      end
      sif.arg_0_TREADY     = rd;
      sif.ila_arg_0_TVALID = iv;
      sif.hls_arg_0_TVALID = hv;
      sif.ila_arg_0_TDATA  = iv ? ila_d[ii] : 8'($urandom);
      sif.hls_arg_0_TDATA  = hv ? hls_d[hi] : 8'($urandom);
      if (iv && rd) begin model_beat(1'b1, ila_d[ii]); ii++; end
      if (hv && rd) begin model_beat(1'b0, hls_d[hi]); hi++; end
      @(posedge ap_clk); #1;
      cyc++;
      if ((ii == n && hi == n) || !m_run) tail++;
    end
    set_idle_inputs();
    if (cyc >= 600) check("drive_budget", 32'(cyc), 0);
  endtask

  task automatic check_verdict(input string name);
    int k = 0;
    bit exp_pass;
    while (busy === 1'b1 && k < 30) begin @(posedge ap_clk); #1; k++; end
    exp_pass = (m_pairs == EXPECT_CNT) && (m_mm == 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_pass"}, 32'(pass), 32'(exp_pass));
    check({name, "_fail"}, 32'(fail), 32'(!exp_pass));
    check({name, "_cmp_cnt"}, 32'(cmp_cnt), m_pairs);
    check({name, "_mismatch_cnt"}, 32'(mismatch_cnt), m_mm);
    check({name, "_first_idx"}, 32'(first_bad_idx), (m_mm != 0) ? m_first_idx : 0);
    check({name, "_first_ila"}, 32'(first_bad_ila), (m_mm != 0) ? 32'(m_first_ila) : 0);
    check({name, "_first_hls"}, 32'(first_bad_hls), (m_mm != 0) ? 32'(m_first_hls) : 0);
    check({name, "_overflow"}, 32'(overflow), 0);
    check({name, "_pending"}, 32'(exp_cnt_q.size()), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_pass"}, 32'(pass), 0);
    check({name, "_fail"}, 32'(fail), 0);
    check({name, "_cmp_cnt"}, 32'(cmp_cnt), 0);
    check({name, "_mismatch_cnt"}, 32'(mismatch_cnt), 0);
    check({name, "_first_idx"}, 32'(first_bad_idx), 0);
    check({name, "_first_ila"}, 32'(first_bad_ila), 0);
    check({name, "_first_hls"}, 32'(first_bad_hls), 0);
    check({name, "_overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    m_run = 0;
    set_idle_inputs();
    repeat (3) @(posedge ap_clk);
    #1;
    check_all_zero("reset");
    #2 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Identical streams, ILA three cycles ahead (fills the ILA FIFO exactly).
    for (int i = 0; i < 64; i++) begin ila_d[i] = 8'($urandom); hls_d[i] = ila_d[i]; end
    do_start();
    drive(16, 3, 1'b0);
    check_verdict("lead3_equal");

    // Single corrupted pair at index 5.
    for (int i = 0; i < 64; i++) begin ila_d[i] = 8'($urandom); hls_d[i] = ila_d[i]; end
    ila_d[5] = 8'h3C;
    hls_d[5] = 8'h3D;
    do_start();
    drive(20, 0, 1'b0);
    check_verdict("pair5_bad");
    check("pair5_first_idx_abs", 32'(first_bad_idx), 5);
    check("pair5_first_ila_abs", 32'(first_bad_ila), 32'h3C);
    check("pair5_first_hls_abs", 32'(first_bad_hls), 32'h3D);

    // Randomised traffic, ready and sparse mismatches.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) begin
        ila_d[i] = 8'($urandom);
        hls_d[i] = ($urandom_range(0, 4) == 0) ? (ila_d[i] ^ 8'($urandom_range(1, 255))) : ila_d[i];
      end
      do_start();
      drive(20, 0, 1'b1);
      check_verdict($sformatf("rand%0d", r));
    end

    // Overflow: five ILA beats into a depth-4 FIFO with no HLS traffic.
    do_start();
    m_run = 0;
    for (int k = 0; k < 5; k++) begin
      sif.ila_arg_0_TVALID = 1'b1;
      sif.ila_arg_0_TDATA  = 8'(k + 1);
      @(posedge ap_clk); #1;
      if (k == 3) begin
        check("ovf_before_overflow", 32'(overflow), 0);
        check("ovf_before_busy", 32'(busy), 1);
      end
    end
    set_idle_inputs();
    check("ovf_overflow", 32'(overflow), 1);
    check("ovf_fail", 32'(fail), 1);
    check("ovf_busy", 32'(busy), 0);
    check("ovf_cmp_cnt", 32'(cmp_cnt), 0);

    // Ready held low: nothing accepted, run stays open.
    do_start();
    sif.arg_0_TREADY     = 1'b0;
    sif.ila_arg_0_TVALID = 1'b1;
    sif.hls_arg_0_TVALID = 1'b1;
    repeat (10) @(posedge ap_clk);
    #1;
    set_idle_inputs();
    check("nordy_cmp_cnt", 32'(cmp_cnt), 0);
    check("nordy_busy", 32'(busy), 1);
    check("nordy_overflow", 32'(overflow), 0);

    // Seven compares, then an asynchronous reset mid-run.
    for (int i = 0; i < 64; i++) begin ila_d[i] = 8'($urandom); hls_d[i] = ila_d[i]; end
    drive(7, 0, 1'b0);
    check("midrun_cmp_cnt", 32'(cmp_cnt), 7);
    check("midrun_busy", 32'(busy), 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_cnt_q.delete();
    exp_mm_q.delete();
    m_run = 0;
    #3 ap_rst_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("post_reset_idle_busy", 32'(busy), 0);
    do_start();
    drive(16, 0, 1'b0);
    check_verdict("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
